// File: rtl/pixel4_stream_ctrl.sv
// -----------------------------------------------------------------------------
// pixel4_stream_ctrl
//
// Job sequencer in front of a four-lane 8-bit pixel ALU. For every 32-bit word
// of a job it reads the word from the source region, presents the four packed
// pixels with a per-job key and function code to the ALU lanes, registers the
// lane results and writes them back to the destination region (4 cycles/word).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_start, i_abort    job request (sampled in idle only) / job cancel
//   i_src_addr          first source word address
//   i_dst_addr          first destination word address
//   i_word_count        number of words in the job
//   i_key, i_fun        lane operandB value and ALU function code (1..7)
//   o_busy              job in progress
//   o_done, o_err       completion pulse / rejected-start or abort pulse
//   o_mem_addr          RAM word address (0 when no strobe is active)
//   o_mem_rd_en         read strobe, data returns on i_mem_rd_data next cycle
//   o_mem_wr_en         write strobe, data on o_mem_wr_data
//   o_alu_a, o_alu_b    lane operands, lane k in bits [8k+7:8k]
//   o_alu_fun           function code shared by all lanes
//   i_alu_res           combinational lane results
// -----------------------------------------------------------------------------
module pixel4_stream_ctrl #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [ADDR_W-1:0] i_dst_addr,
    input  logic [ADDR_W-1:0] i_word_count,
    input  logic [7:0]        i_key,
    input  logic [2:0]        i_fun,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd_en,
    input  logic [31:0]       i_mem_rd_data,
    output logic              o_mem_wr_en,
    output logic [31:0]       o_mem_wr_data,
    output logic [31:0]       o_alu_a,
    output logic [31:0]       o_alu_b,
    output logic [2:0]        o_alu_fun,
    input  logic [31:0]       i_alu_res
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StExec,
        StWrite,
        StDone
    } state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_res;
    logic [31:0]       r_alu_a;
    logic [31:0]       r_alu_b;
    logic [2:0]        r_alu_fun;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_rd_en;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_addr;

    logic [7:0]        w_key;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              w_last;
    logic              w_wr_en;

    // Shift/rotate functions only use a 0..7 distance, so the key is trimmed.
    assign w_key     = (i_fun >= 3'd4) ? {5'b0, i_key[2:0]} : i_key;
    assign w_idx_nxt = r_idx + ADDR_W'(1);
    assign w_last    = (r_idx == r_count - ADDR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_src     <= '0;
            r_dst     <= '0;
            r_count   <= '0;
            r_idx     <= '0;
            r_res     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_fun <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_addr    <= '0;
        end else begin
            // Pulses and strobes default low; the addressed states re-assert them.
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_addr  <= '0;

            if (i_abort && r_busy) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
                r_idx   <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        // A simultaneous abort swallows the start without an error.
                        if (i_start && !i_abort) begin
                            if (i_fun == 3'd0) begin
                                r_err <= 1'b1;
                            end else if (i_word_count == '0) begin
                                r_done  <= 1'b1;
                                r_state <= StDone;
                            end else begin
                                r_src     <= i_src_addr;
                                r_dst     <= i_dst_addr;
                                r_count   <= i_word_count;
                                r_idx     <= '0;
                                r_alu_fun <= i_fun;
                                r_alu_b   <= {4{w_key}};
                                r_busy    <= 1'b1;
                                r_rd_en   <= 1'b1;
                                r_addr    <= i_src_addr;
                                r_state   <= StRead;
                            end
                        end
                    end
                    StRead: begin
                        r_state <= StWait;
                    end
                    StWait: begin
                        // The pixel register doubles as the operandA output.
                        r_alu_a <= i_mem_rd_data;
                        r_state <= StExec;
                    end
                    StExec: begin
                        r_res   <= i_alu_res;
                        r_wr_en <= 1'b1;
                        r_addr  <= r_dst + r_idx;
                        r_state <= StWrite;
                    end
                    StWrite: begin
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            r_rd_en <= 1'b1;
                            r_addr  <= r_src + w_idx_nxt;
                            r_state <= StRead;
                        end
                    end
                    StDone: begin
                        r_idx   <= '0;
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    // An abort arriving in the write cycle must cancel that write immediately.
    assign w_wr_en       = r_wr_en && !i_abort;

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_mem_rd_en   = r_rd_en;
    assign o_mem_wr_en   = w_wr_en;
    assign o_mem_addr    = (r_rd_en || w_wr_en) ? r_addr : '0;
    assign o_mem_wr_data = w_wr_en ? r_res : '0;
    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_fun     = r_alu_fun;

endmodule

// File: tb/tb_pixel4_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pixel4_stream_ctrl
//
// Bench for pixel4_stream_ctrl: a synchronous RAM and a four-lane ALU form the
// environment; a job-level reference model predicts strobes, timing and the
// resulting memory image from the job parameters alone.
// -----------------------------------------------------------------------------
module tb_pixel4_stream_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [AW-1:0] src_addr, dst_addr, word_count;
    logic [7:0]    key;
    logic [2:0]    fun;
    logic          busy, done, err;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en, mem_wr_en;
    logic [31:0]   mem_rd_data, mem_wr_data;
    logic [31:0]   alu_a, alu_b, alu_res;
    logic [2:0]    alu_fun;

    logic [31:0]   ram     [0:NW-1];
    logic [31:0]   ref_mem [0:NW-1];
    logic [31:0]   scratch [0:NW-1];
    logic [31:0]   wd      [0:63];
    logic [31:0]   rdw     [0:63];

    logic          bk_we;
    logic [AW-1:0] bk_addr;
    logic [31:0]   bk_data;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pixel4_stream_ctrl #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_src_addr   (src_addr),
        .i_dst_addr   (dst_addr),
        .i_word_count (word_count),
        .i_key        (key),
        .i_fun        (fun),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_mem_addr   (mem_addr),
        .o_mem_rd_en  (mem_rd_en),
        .i_mem_rd_data(mem_rd_data),
        .o_mem_wr_en  (mem_wr_en),
        .o_mem_wr_data(mem_wr_data),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_fun    (alu_fun),
        .i_alu_res    (alu_res)
    );

    // Lane arithmetic of the pixel ALU: add/sub fold the carry/borrow back in
    // (end-around carry); shifts and rotates use the low 3 bits of operandB.
    function automatic logic [7:0] lane_op(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] f);
        int p, k, r;
        p = int'(a);
        k = int'(b);
        case (f)
            3'd1: begin r = p + k; if (r > 255) r = r - 255; end
            3'd2: begin r = p - k; if (r < 0) r = r + 255; end
            3'd3: r = p ^ k;
            3'd4: r = p >> (k % 8);
            3'd5: r = (p << (k % 8)) % 256;
            3'd6: r = ((p >> (k % 8)) | (p << (8 - k % 8))) % 256;
            3'd7: r = ((p << (k % 8)) | (p >> (8 - k % 8))) % 256;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    function automatic logic [31:0] word_op(input logic [31:0] w, input logic [7:0] k,
                                            input logic [2:0] f);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = lane_op(w[8*i +: 8], k, f);
        return o;
    endfunction

    always_comb begin
        alu_res = '0;
        for (int i = 0; i < 4; i++) alu_res[8*i +: 8] = lane_op(alu_a[8*i +: 8], alu_b[8*i +: 8], alu_fun);
    end

    // Synchronous RAM with a bench-side preload port.
    always @(posedge clk) begin
        if (bk_we) ram[bk_addr] <= bk_data;
        else if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        @(posedge clk); #1;
        bk_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic mem_check(input string tag);
        int bad = 0;
        for (int i = 0; i < int'(NW); i++) if (ram[i] !== ref_mem[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    // One job, checked cycle by cycle. abort_cyc: -1 none, 0 abort with the
    // start, >0 abort raised in that cycle. junk: scribble on inputs while busy.
    task automatic run_job(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW-1:0] cnt, input logic [7:0] k,
                           input logic [2:0] f, input int abort_cyc, input bit junk);
        int n, last, jlast;
        bit valid, go, zero, aborted;
        bit e_busy, e_done, e_err, e_rd, e_wr;
        logic [AW-1:0] e_addr, a;
        logic [7:0] km;
        n       = int'(cnt);
        valid   = (f != 3'd0);
        go      = valid && abort_cyc != 0 && n > 0;
        zero    = valid && abort_cyc != 0 && n == 0;
        aborted = go && abort_cyc >= 1 && abort_cyc <= 4 * n;
        km      = (f >= 3'd4) ? (k & 8'h07) : k;
        last    = go ? (aborted ? abort_cyc + 1 : 4 * n + 1) : 1;
        jlast   = aborted ? abort_cyc : 4 * n + 1;

        for (int i = 0; i < int'(NW); i++) scratch[i] = ref_mem[i];
        for (int i = 0; i < n; i++) begin
            a = s + AW'(i);
            rdw[i] = scratch[a];
            wd[i]  = word_op(rdw[i], km, f);
            a = d + AW'(i);
            scratch[a] = wd[i];
        end

        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; word_count = cnt; key = k; fun = f;
        abort = (abort_cyc == 0);
        for (int c = 1; c <= last + 2; c++) begin
            @(posedge clk); #1;
            abort = (c == abort_cyc);
            if (junk && go && c <= jlast) begin
                start = 1'($urandom); fun = 3'($urandom); key = 8'($urandom);
                src_addr = AW'($urandom); dst_addr = AW'($urandom); word_count = AW'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            e_busy = go && c <= 4 * n && !(aborted && c > abort_cyc);
            e_done = (go && !aborted && c == 4 * n + 1) || (zero && c == 1);
            e_err  = (!valid && abort_cyc != 0 && c == 1) || (aborted && c == abort_cyc + 1);
            e_rd   = e_busy && (c % 4 == 1);
            e_wr   = e_busy && (c % 4 == 0) && c != abort_cyc;
            e_addr = e_rd ? s + AW'((c - 1) / 4) : (e_wr ? d + AW'(c / 4 - 1) : '0);
            check("ctl", {17'b0, busy, done, err, mem_rd_en, mem_wr_en, mem_addr},
                  {17'b0, e_busy, e_done, e_err, e_rd, e_wr, e_addr});
            if (e_wr) check("wdata", mem_wr_data, wd[c / 4 - 1]);
            if (e_busy && c % 4 == 3) begin
                check("alu_a", alu_a, rdw[(c - 3) / 4]);
                check("alu_b", alu_b, {4{km}});
                check("alu_fun", {29'b0, alu_fun}, {29'b0, f});
            end
        end
        abort = 1'b0;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (go && (!aborted || 4 * i + 4 < abort_cyc)) begin
                a = d + AW'(i);
                ref_mem[a] = wd[i];
            end
        end
        mem_check("mem");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; bk_we = 1'b0; bk_addr = '0; bk_data = '0;
        src_addr = '0; dst_addr = '0; word_count = '0; key = '0; fun = '0;
        #1;
        check("reset_ctl", {17'b0, busy, done, err, mem_rd_en, mem_wr_en, mem_addr}, 32'd0);
        for (int i = 0; i < int'(NW); i++) poke(AW'(i), $urandom);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_alu_b", alu_b, 32'd0);
        check("reset_fun_wdata", {29'b0, alu_fun} | mem_wr_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Add with wrap: 0xC8 + 100 folds to 0x2D.
        poke(10'd10, 32'hC8C8_0A00);
        run_job(10'd10, 10'd20, 10'd1, 8'd100, 3'd1, -1, 1'b0);
        check("add_word", ram[20], 32'h2D2D_6E64);

        // Subtract over two words, borrow folds 0x0A - 0x14 to 0xF5.
        poke(10'd30, 32'h0A0A_0A0A);
        poke(10'd31, 32'h1E1E_1E1E);
        run_job(10'd30, 10'd40, 10'd2, 8'd20, 3'd2, -1, 1'b0);
        check("sub_word0", ram[40], 32'hF5F5_F5F5);
        check("sub_word1", ram[41], 32'h0A0A_0A0A);

        // Rotate right with key trimmed to 1.
        poke(10'd50, 32'h8181_8181);
        run_job(10'd50, 10'd60, 10'd1, 8'h09, 3'd6, -1, 1'b0);
        check("rotr_word", ram[60], 32'hC0C0_C0C0);

        // Rejected start, then empty job.
        run_job(10'd5, 10'd6, 10'd3, 8'd1, 3'd0, -1, 1'b0);
        run_job(10'd5, 10'd6, 10'd0, 8'd1, 3'd1, -1, 1'b0);

        // Abort during the second word's write, then a normal job.
        run_job(10'd100, 10'd200, 10'd4, 8'h5A, 3'd3, 8, 1'b0);
        run_job(10'd100, 10'd200, 10'd4, 8'h5A, 3'd3, -1, 1'b0);

        // In-place across the address wrap.
        poke(10'd1023, 32'h1234_5678);
        poke(10'd0, 32'hA5A5_0F0F);
        run_job(10'd1023, 10'd1023, 10'd2, 8'hFF, 3'd3, -1, 1'b0);
        check("wrap_word0", ram[1023], 32'hEDCB_A987);
        check("wrap_word1", ram[0], 32'h5A5A_F0F0);

        // Start and abort together in idle: nothing happens.
        run_job(10'd7, 10'd8, 10'd2, 8'd3, 3'd1, 0, 1'b0);

        // Randomized jobs with input noise while busy and occasional aborts.
        for (int j = 0; j < 12; j++) begin
            int nn, ab;
            nn = int'($urandom_range(1, 6));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4 * nn)) : -1;
            run_job(AW'($urandom), AW'($urandom), AW'(nn), 8'($urandom),
                    3'($urandom_range(1, 7)), ab, 1'b1);
        end

        // Reset in the middle of a write cycle: outputs clear, no write lands.
        @(posedge clk); #1;
        start = 1'b1; src_addr = 10'd300; dst_addr = 10'd400; word_count = 10'd2;
        key = 8'd1; fun = 3'd1;
        repeat (4) begin @(posedge clk); #1; start = 1'b0; end
        rst_n = 1'b0;
        #1;
        check("midrst_ctl", {17'b0, busy, done, err, mem_rd_en, mem_wr_en, mem_addr}, 32'd0);
        check("midrst_alu", alu_a | alu_b | {29'b0, alu_fun} | mem_wr_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        mem_check("midrst_mem");
        run_job(10'd300, 10'd400, 10'd2, 8'd1, 3'd5, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
